// File: rtl/dft_bin_accumulator.sv
// rtl/dft_bin_accumulator.sv - single-bin DFT accumulator: sums N product pairs, emits X[k]; optional macro DFT_ACC_SCALE_EN gives 1/N scaled output
module dft_bin_accumulator #(
  parameter int WIDTH     = 12,
  parameter int LOG_N_MAX = 10,
  parameter int ACC_WIDTH = 22
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst_n,
  input  logic                        i_start,
  input  logic [4:0]                  i_log_n,
  input  logic signed [WIDTH-1:0]     i_re,
  input  logic signed [WIDTH-1:0]     i_im,
  input  logic                        i_done,
  output logic [LOG_N_MAX-1:0]        o_n,
  output logic signed [ACC_WIDTH-1:0] o_X_re,
  output logic signed [ACC_WIDTH-1:0] o_X_im,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic                        o_ovf
);

  localparam int LN_W = $clog2(LOG_N_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_done_q;
  logic [LOG_N_MAX-1:0]          r_n;
  logic [LOG_N_MAX-1:0]          r_nmax;
  logic signed [ACC_WIDTH-1:0]   r_acc_re;
  logic signed [ACC_WIDTH-1:0]   r_acc_im;
  logic signed [ACC_WIDTH-1:0]   r_X_re;
  logic signed [ACC_WIDTH-1:0]   r_X_im;
  logic                          r_valid;
  logic                          r_ovf;
`ifdef DFT_ACC_SCALE_EN
  logic [LN_W-1:0]               r_ln;
`endif

  logic                          w_ev;
  logic                          w_last;
  logic [LN_W-1:0]               w_ln;
  logic [LOG_N_MAX-1:0]          w_nmax;
  logic signed [ACC_WIDTH-1:0]   w_re_ext;
  logic signed [ACC_WIDTH-1:0]   w_im_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum_re;
  logic signed [ACC_WIDTH-1:0]   w_sum_im;
  logic                          w_ovf_re;
  logic                          w_ovf_im;

  assign w_ev     = i_done & ~r_done_q;
  assign w_last   = (r_n == r_nmax);
  assign w_re_ext = ACC_WIDTH'(i_re);
  assign w_im_ext = ACC_WIDTH'(i_im);
  assign w_sum_re = r_acc_re + w_re_ext;
  assign w_sum_im = r_acc_im + w_im_ext;
  // Wrap detection: operands agree in sign but the sum does not.
  assign w_ovf_re = (r_acc_re[ACC_WIDTH-1] == w_re_ext[ACC_WIDTH-1]) &&
                    (w_sum_re[ACC_WIDTH-1] != r_acc_re[ACC_WIDTH-1]);
  assign w_ovf_im = (r_acc_im[ACC_WIDTH-1] == w_im_ext[ACC_WIDTH-1]) &&
                    (w_sum_im[ACC_WIDTH-1] != r_acc_im[ACC_WIDTH-1]);
  // N-1 as a mask; at lN = LOG_N_MAX every bit shifts out giving all ones.
  assign w_nmax   = ~({LOG_N_MAX{1'b1}} << w_ln);

  // Clamp requested transform length to the largest supported one.
  always_comb begin
    w_ln = LN_W'(i_log_n);
    if (int'(i_log_n) > LOG_N_MAX) begin
      w_ln = LN_W'(LOG_N_MAX);
    end
  end

  // Next-state logic; a start pulse restarts from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: if (w_ev && w_last) w_state_nxt = S_DUMP;
        S_DUMP:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: edge detect, accumulation, index counter and bin output.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_done_q <= 1'b0;
      r_n      <= '0;
      r_nmax   <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_X_re   <= '0;
      r_X_im   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef DFT_ACC_SCALE_EN
      r_ln     <= '0;
`endif
    end else begin
      r_done_q <= i_done;
      r_valid  <= 1'b0;
      if (i_start) begin
        r_n      <= '0;
        r_nmax   <= w_nmax;
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_ovf    <= 1'b0;
`ifdef DFT_ACC_SCALE_EN
        r_ln     <= w_ln;
`endif
      end else if (r_state == S_ACCUM && w_ev) begin
        r_acc_re <= w_sum_re;
        r_acc_im <= w_sum_im;
        r_ovf    <= r_ovf | w_ovf_re | w_ovf_im;
        if (!w_last) begin
          r_n <= r_n + LOG_N_MAX'(1);
        end
      end else if (r_state == S_DUMP) begin
`ifdef DFT_ACC_SCALE_EN
        r_X_re <= r_acc_re >>> r_ln;
        r_X_im <= r_acc_im >>> r_ln;
`else
        r_X_re <= r_acc_re;
        r_X_im <= r_acc_im;
`endif
        r_valid <= 1'b1;
      end
    end
  end

  assign o_n     = r_n;
  assign o_X_re  = r_X_re;
  assign o_X_im  = r_X_im;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != S_IDLE);
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_dft_bin_accumulator.sv
// tb/tb_dft_bin_accumulator.sv - scoreboard bench for dft_bin_accumulator (default and 12-bit accumulator instances)
module tb_dft_bin_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [4:0]         log_n;
  logic signed [11:0] re_drv;
  logic signed [11:0] im_drv;
  logic               done;

  logic [9:0]         a_n;
  logic signed [21:0] a_X_re;
  logic signed [21:0] a_X_im;
  logic               a_valid, a_busy, a_ovf;

  logic [9:0]         b_n;
  logic signed [11:0] b_X_re;
  logic signed [11:0] b_X_im;
  logic               b_valid, b_busy, b_ovf;

  typedef struct {
    int re;
    int im;
    int ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dft_bin_accumulator #(.WIDTH(12), .LOG_N_MAX(10), .ACC_WIDTH(22)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_start(start), .i_log_n(log_n),
    .i_re(re_drv), .i_im(im_drv), .i_done(done),
    .o_n(a_n), .o_X_re(a_X_re), .o_X_im(a_X_im),
    .o_valid(a_valid), .o_busy(a_busy), .o_ovf(a_ovf)
  );

  dft_bin_accumulator #(.WIDTH(12), .LOG_N_MAX(10), .ACC_WIDTH(12)) dut_ovf (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_start(start), .i_log_n(log_n),
    .i_re(re_drv), .i_im(im_drv), .i_done(done),
    .o_n(b_n), .o_X_re(b_X_re), .o_X_im(b_X_im),
    .o_valid(b_valid), .o_busy(b_busy), .o_ovf(b_ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raw and 1/N-scaled expectations for both instances are hand-computed.
  task automatic push_exp(input int ar, input int ai, input int ao,
                          input int br, input int bi, input int bo);
    exp_t e;
    e.re = ar; e.im = ai; e.ovf = ao; q_a.push_back(e);
    e.re = br; e.im = bi; e.ovf = bo; q_b.push_back(e);
  endtask

  task automatic start_frame(input int lg);
    @(negedge clk);
    start = 1'b1;
    log_n = 5'(lg);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sample(input int re, input int im, input int hold,
                        input bit chk_n, input int exp_n);
    if (chk_n) check("o_n", int'(a_n), exp_n);
    re_drv = 12'(re);
    im_drv = 12'(im);
    done   = 1'b1;
    repeat (hold) @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while ((a_busy || b_busy) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0d expected 0", a_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare each presented bin against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got valid=1 expected 0");
      end else begin
        e = q_a.pop_front();
        check("a_X_re", int'(a_X_re), e.re);
        check("a_X_im", int'(a_X_im), e.im);
        check("a_ovf", int'(a_ovf), e.ovf);
      end
    end
    if (b_valid) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got valid=1 expected 0");
      end else begin
        e = q_b.pop_front();
        check("b_X_re", int'(b_X_re), e.re);
        check("b_X_im", int'(b_X_im), e.im);
        check("b_ovf", int'(b_ovf), e.ovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; log_n = '0;
    re_drv = '0; im_drv = '0; done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(a_valid), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_n_idx", int'(a_n), 0);
    check("rst_X_re", int'(a_X_re), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 4-sample frame, o_n stepping 0..3.
    start_frame(2);
    check("busy_accum", int'(a_busy), 1);
`ifdef DFT_ACC_SCALE_EN
    push_exp(4, 1, 0, 4, 1, 0);
`else
    push_exp(16, 5, 0, 16, 5, 0);
`endif
    sample(5, -1, 1, 1'b1, 0);
    sample(3, 2, 1, 1'b1, 1);
    sample(-2, 4, 1, 1'b1, 2);
    sample(10, 0, 1, 1'b1, 3);
    wait_idle();

    // Asynchronous reset after 3 of 4 samples clears everything at once.
    start_frame(2);
    sample(7, 7, 1, 1'b0, 0);
    sample(7, 7, 1, 1'b0, 0);
    sample(7, 7, 1, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_X_re", int'(a_X_re), 0);
    check("arst_X_im", int'(a_X_im), 0);
    check("arst_busy", int'(a_busy), 0);
    check("arst_n_idx", int'(a_n), 0);
    check("arst_ovf", int'(b_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // N = 1: valid two negedges after the done edge is raised.
    start_frame(0);
    push_exp(-7, 7, 0, -7, 7, 0);
    re_drv = -12'sd7;
    im_drv = 12'sd7;
    done = 1'b1;
    @(negedge clk);
    check("lat_early", int'(a_valid), 0);
    @(negedge clk);
    check("lat_hit", int'(a_valid), 1);
    done = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();

    // Level held high for 6 cycles counts once per rising edge.
    start_frame(2);
`ifdef DFT_ACC_SCALE_EN
    push_exp(1, 2, 0, 1, 2, 0);
`else
    push_exp(4, 8, 0, 4, 8, 0);
`endif
    for (int i = 0; i < 4; i++) sample(1, 2, 6, 1'b1, i);
    wait_idle();

    // Restart after 2 samples: only post-restart samples count.
    start_frame(2);
    sample(100, 100, 1, 1'b0, 0);
    sample(100, 100, 1, 1'b0, 0);
    start_frame(2);
    check("abort_n_idx", int'(a_n), 0);
`ifdef DFT_ACC_SCALE_EN
    push_exp(2, -3, 0, 2, -3, 0);
`else
    push_exp(10, -10, 0, 10, -10, 0);
`endif
    for (int i = 1; i <= 4; i++) sample(i, -i, 1, 1'b1, i - 1);
    wait_idle();

    // Full-scale sum: wraps and flags overflow only in the 12-bit instance.
    start_frame(2);
`ifdef DFT_ACC_SCALE_EN
    push_exp(2047, 0, 0, -1, 0, 1);
`else
    push_exp(8188, 0, 0, -4, 0, 1);
`endif
    for (int i = 0; i < 4; i++) sample(2047, 0, 1, 1'b0, 0);
    wait_idle();

    // i_log_n = 15 clamps to 1024 samples.
    start_frame(15);
`ifdef DFT_ACC_SCALE_EN
    push_exp(1, -1, 0, 1, -1, 0);
`else
    push_exp(1024, -1024, 0, 1024, -1024, 0);
`endif
    for (int i = 0; i < 1024; i++) sample(1, -1, 1, (i == 1023), i);
    wait_idle();

    repeat (5) @(negedge clk);
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
